btb_train_ctrl: RTL



---
 rtl/btb_ctrl_pkg.sv | 24 ++
 rtl/btb_tr_queue.sv | 71 +++++++
 rtl/btb_train_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/btb_ctrl_pkg.sv
// btb_ctrl_pkg: shared types and defaults for the BTB write-side controller.
//   - BTB_ADDR_W / BTB_TABLE_DEPTH / BTB_TR_QUEUE_DEPTH : configuration defaults
//   - btb_ctrl_state_e : flush sequencer state encoding
//   - btb_tr_ent_t     : one buffered training event
package btb_ctrl_pkg;

  localparam int BTB_ADDR_W         = 32;
  localparam int BTB_TABLE_DEPTH    = 8;
  localparam int BTB_TR_QUEUE_DEPTH = 4;

  typedef enum logic {
    BTB_CTRL_IDLE = 1'b0,
    BTB_CTRL_WALK = 1'b1
  } btb_ctrl_state_e;

  // The address fields are sized by BTB_ADDR_W. The top checks at elaboration
  // that its ADDR parameter matches this width.
  typedef struct packed {
    logic                  taken_;
    logic [BTB_ADDR_W-1:0] addr;
    logic [BTB_ADDR_W-1:0] tar_addr;
  } btb_tr_ent_t;

endpackage

// File: rtl/btb_tr_queue.sv
// btb_tr_queue: multi-push (SIMBRCOM), single-pop in-order FIFO of training
// events. Active slots in a push are compacted into consecutive entries in
// ascending slot order. flush empties the queue by snapping rd to wr. A flush
// also suppresses any push or pop in the same cycle.
//   clk, reset_         : clock, async active-low reset (pointers only)
//   push_en             : caller permits pushing this cycle (caller checks room)
//   push_[SIMBRCOM]     : per-slot push, active-low
//   push_data[SIMBRCOM] : per-slot payload
//   pop                 : remove head (ignored when empty)
//   flush               : discard all entries
//   head                : entry at rd
//   count               : wr - rd
module btb_tr_queue
  import btb_ctrl_pkg::*;
#(
  parameter int SIMBRCOM = 2,
  parameter int QDEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          push_en,
  input  logic [SIMBRCOM-1:0]           push_,
  input  btb_tr_ent_t [SIMBRCOM-1:0]    push_data,
  input  logic                          pop,
  input  logic                          flush,
  output btb_tr_ent_t                   head,
  output logic [$clog2(QDEPTH):0]       count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;   // the extra bit separates full from empty

  btb_tr_ent_t               mem [QDEPTH];
  logic [PW-1:0]             rd, wr;
  logic [SIMBRCOM-1:0]       push_v;
  logic [SIMBRCOM-1:0][PW-1:0] slot_ofs;
  logic [PW-1:0]             n_push;
  logic                      do_pop;

  assign push_v = (push_en && !flush) ? ~push_ : '0;
  assign count  = wr - rd;
  assign do_pop = pop && !flush && (count != '0);
  assign head   = mem[rd[AW-1:0]];

  // Offset of each slot = number of active slots below it. Idle slots are
  // skipped, which closes the gaps.
  always_comb begin
    slot_ofs[0] = '0;
    for (int i = 1; i < SIMBRCOM; i++)
      slot_ofs[i] = slot_ofs[i-1] + PW'(push_v[i-1]);
    n_push = slot_ofs[SIMBRCOM-1] + PW'(push_v[SIMBRCOM-1]);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SIMBRCOM; i++)
      if (push_v[i]) mem[AW'(wr + slot_ofs[i])] <= push_data[i];
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd <= '0;
      wr <= '0;
    end else if (flush) begin
      rd <= wr;
    end else begin
      wr <= wr + n_push;
      if (do_pop) rd <= rd + PW'(1);
    end
  end

endmodule

// File: rtl/btb_train_ctrl.sv
// btb_train_ctrl: sequences all write traffic into the BTB.
// Commit-time training events (up to SIMBRCOM per cycle) go into an in-order
// queue and issue one per cycle on the tr_* port. A flush request drops the
// queue and walks every BTB entry through the invalidate port.
//   clk, reset_               : clock, async active-low reset
//   com_, com_taken_          : per-slot commit / taken, active-low
//   com_addr, com_tar_addr    : per-slot PC / target, slot i at [i*ADDR +: ADDR]
//   com_stall                 : commit must hold; this cycle's slots are not taken
//   flush_req                 : pulse, discard queue and invalidate whole BTB
//   flush_busy                : invalidate walk in progress
//   tr_commit_, tr_taken_,
//   tr_addr, tr_tar_addr      : registered train strobe (active-low) and payload
//   inv_en, inv_idx           : registered invalidate strobe and entry index
module btb_train_ctrl
  import btb_ctrl_pkg::*;
#(
  parameter int ADDR     = BTB_ADDR_W,
  parameter int BTB_D    = BTB_TABLE_DEPTH,
  parameter int SIMBRCOM = 2,
  parameter int QDEPTH   = BTB_TR_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [SIMBRCOM-1:0]        com_,
  input  logic [SIMBRCOM-1:0]        com_taken_,
  input  logic [SIMBRCOM*ADDR-1:0]   com_addr,
  input  logic [SIMBRCOM*ADDR-1:0]   com_tar_addr,
  output logic                       com_stall,
  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic                       tr_commit_,
  output logic                       tr_taken_,
  output logic [ADDR-1:0]            tr_addr,
  output logic [ADDR-1:0]            tr_tar_addr,
  output logic                       inv_en,
  output logic [$clog2(BTB_D)-1:0]   inv_idx
);

  localparam int IW = $clog2(BTB_D);
  localparam int CW = $clog2(QDEPTH) + 1;

  if (ADDR != BTB_ADDR_W) begin : g_bad_addr
    $error("btb_train_ctrl: ADDR must equal btb_ctrl_pkg::BTB_ADDR_W");
  end
  if (QDEPTH < SIMBRCOM || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
    $error("btb_train_ctrl: QDEPTH must be a power of 2 and >= SIMBRCOM");
  end
  if ((BTB_D & (BTB_D - 1)) != 0 || BTB_D < 2) begin : g_bad_btb_d
    $error("btb_train_ctrl: BTB_D must be a power of 2 and >= 2");
  end

  btb_ctrl_state_e             state;
  btb_tr_ent_t [SIMBRCOM-1:0]  slot_ent;
  btb_tr_ent_t                 q_head;
  logic [CW-1:0]               q_count;
  logic [CW-1:0]               q_free;
  logic                        accept;
  logic                        pop;

  always_comb begin
    slot_ent = '0;
    for (int i = 0; i < SIMBRCOM; i++) begin
      slot_ent[i].taken_   = com_taken_[i];
      slot_ent[i].addr     = com_addr[i*ADDR +: ADDR];
      slot_ent[i].tar_addr = com_tar_addr[i*ADDR +: ADDR];
    end
  end

  // Stall is a function of registered state only, so commit never sees a
  // combinational path back from its own inputs. A flush request landing in
  // a non-stalled cycle still drops that cycle's slots; the queue suppresses
  // the push.
  assign q_free    = CW'(QDEPTH) - q_count;
  assign com_stall = (q_free < CW'(SIMBRCOM)) || (state != BTB_CTRL_IDLE);
  assign accept    = !com_stall;
  assign pop       = (state == BTB_CTRL_IDLE) && !flush_req && (q_count != '0);

  btb_tr_queue #(
    .SIMBRCOM (SIMBRCOM),
    .QDEPTH   (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_    (reset_),
    .push_en   (accept),
    .push_     (com_),
    .push_data (slot_ent),
    .pop       (pop),
    .flush     (flush_req),
    .head      (q_head),
    .count     (q_count)
  );

  // Issue register. The payload holds between strobes. Because pop is
  // suppressed during a walk and in the flush cycle, no strobe can coincide
  // with inv_en.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      tr_commit_  <= 1'b1;
      tr_taken_   <= 1'b1;
      tr_addr     <= '0;
      tr_tar_addr <= '0;
    end else begin
      tr_commit_ <= !pop;
      if (pop) begin
        tr_taken_   <= q_head.taken_;
        tr_addr     <= q_head.addr;
        tr_tar_addr <= q_head.tar_addr;
      end
    end
  end

  // Flush sequencer. inv_idx follows the entry being invalidated. A repeated
  // flush_req restarts the walk from entry 0.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= BTB_CTRL_IDLE;
      inv_en     <= 1'b0;
      inv_idx    <= '0;
      flush_busy <= 1'b0;
    end else begin
      case (state)
        BTB_CTRL_IDLE: begin
          if (flush_req) begin
            state      <= BTB_CTRL_WALK;
            inv_en     <= 1'b1;
            inv_idx    <= '0;
            flush_busy <= 1'b1;
          end
        end
        BTB_CTRL_WALK: begin
          if (flush_req) begin
            inv_idx <= '0;
          end else if (inv_idx == IW'(BTB_D - 1)) begin
            state      <= BTB_CTRL_IDLE;
            inv_en     <= 1'b0;
            inv_idx    <= '0;
            flush_busy <= 1'b0;
          end else begin
            inv_idx <= inv_idx + IW'(1);
          end
        end
        default: state <= BTB_CTRL_IDLE;
      endcase
    end
  end

endmodule
